// File: rtl/i4001_bank.sv
// Bank of NUM_ROMS contiguous 4001 ROM/IO chips on the MCS-4 4-bit bus.
// It handles instruction fetch, SRC chip select, WRR/RDR port I/O and debug access to the ROM contents.
module i4001_bank #(
  parameter int                    NUM_ROMS = 4,
  parameter int                    BASE_ID  = 0,
  parameter logic [4*NUM_ROMS-1:0] IO_MASK  = {NUM_ROMS{4'hF}},
  parameter                        ROM_FILE = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  input  logic                    cl_rom,
  input  logic                    cm_rom,
  input  logic [3:0]              dbus_in,
  output logic [3:0]              dbus_out,
  output logic                    dbus_oe,
  input  logic [4*NUM_ROMS-1:0]   io_in,
  output logic [4*NUM_ROMS-1:0]   io_out,
  input  logic [11:0]             dbg_addr,
  input  logic [7:0]              dbg_wdata,
  input  logic                    dbg_wen,
  input  logic                    dbg_ren,
  output logic [7:0]              dbg_rdata,
  output logic                    dbg_rdata_vld
);

  localparam int DEPTH = NUM_ROMS * 256;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0, PH_A2 = 3'd1, PH_A3 = 3'd2, PH_M1 = 3'd3,
    PH_M2 = 3'd4, PH_X1 = 3'd5, PH_X2 = 3'd6, PH_X3 = 3'd7
  } phase_t;

  // A negative offset wraps far above NUM_ROMS, so one compare covers both ends.
  function automatic logic id_in_range(input logic [3:0] id);
    logic [5:0] d;
    d = {2'b00, id} - 6'(BASE_ID);
    return d < 6'(NUM_ROMS);
  endfunction

  function automatic logic [3:0] chip_off(input logic [3:0] id);
    return id - 4'(BASE_ID);
  endfunction

  logic [7:0]           mem [DEPTH];
  phase_t               phase_r, phase_nxt_s;
  logic                 active_r;
  logic [3:0]           addr_lo_r, addr_mid_r, addr_chip_r;
  logic [7:0]           rdata_r;
  logic                 io_cmd_vld_r;
  logic [3:0]           opa_r, chip_sel_r;
  logic [3:0]           io_lat_r [NUM_ROMS];
  logic [4*NUM_ROMS-1:0] io_s1_r, io_s2_r;
  logic                 sel_hit_s, fetch_hit_s, rdr_s, wrr_s;
  logic [3:0]           sel_off_s, rd_val_s;

  // ROM storage: debug writes only; contents survive reset
  always_ff @(posedge clk) begin
    if (dbg_wen && id_in_range(dbg_addr[11:8])) begin
      mem[AW'({chip_off(dbg_addr[11:8]), dbg_addr[7:0]})] <= dbg_wdata;
    end
  end

  // Phase tracking: idle at A1 until the first sync after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r  <= PH_A1;
      active_r <= 1'b0;
    end else begin
      phase_r  <= phase_nxt_s;
      active_r <= active_r | sync;
    end
  end

  // Next phase
  always_comb begin
    phase_nxt_s = phase_r;
    if (sync) begin
      phase_nxt_s = PH_A1;
    end else if (active_r) begin
      phase_nxt_s = phase_t'(phase_r + 3'd1);
    end else begin
      phase_nxt_s = phase_r;
    end
  end

  // Address nibble capture and fetch read on the A3 edge
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lo_r   <= 4'h0;
      addr_mid_r  <= 4'h0;
      addr_chip_r <= 4'h0;
      rdata_r     <= 8'h00;
    end else if (active_r) begin
      case (phase_r)
        PH_A1: addr_lo_r  <= dbus_in;
        PH_A2: addr_mid_r <= dbus_in;
        PH_A3: begin
          addr_chip_r <= dbus_in;
          rdata_r     <= id_in_range(dbus_in) ?
                         mem[AW'({chip_off(dbus_in), addr_mid_r, addr_lo_r})] : 8'h00;
        end
        default: ;
      endcase
    end
  end

  // I/O command and SRC chip select capture
  always_ff @(posedge clk) begin
    if (rst) begin
      io_cmd_vld_r <= 1'b0;
      opa_r        <= 4'h0;
      chip_sel_r   <= 4'h0;
    end else if (active_r && phase_r == PH_M2) begin
      io_cmd_vld_r <= cm_rom;
      if (cm_rom) opa_r <= dbus_in;
    end else if (active_r && phase_r == PH_X2 && cm_rom) begin
      chip_sel_r <= dbus_in;
    end
  end

  assign sel_hit_s   = id_in_range(chip_sel_r);
  assign sel_off_s   = chip_off(chip_sel_r);
  assign fetch_hit_s = id_in_range(addr_chip_r);
  assign rdr_s = active_r && phase_r == PH_X2 && io_cmd_vld_r && opa_r == 4'hA && sel_hit_s;
  assign wrr_s = active_r && phase_r == PH_X2 && io_cmd_vld_r && opa_r == 4'h2 && sel_hit_s;

  // Pin synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      io_s1_r <= '0;
      io_s2_r <= '0;
    end else begin
      io_s1_r <= io_in;
      io_s2_r <= io_s1_r;
    end
  end

  // Output latches: clear wins over a same-cycle WRR; input-mask bits stay 0
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_ROMS; k++) begin
      if (rst || cl_rom) begin
        io_lat_r[k] <= 4'h0;
      end else if (wrr_s && sel_off_s == 4'(k)) begin
        io_lat_r[k] <= ~IO_MASK[4*k +: 4] & dbus_in;
      end
    end
  end

  // RDR value mux and packed port view
  always_comb begin
    rd_val_s = 4'h0;
    io_out   = '0;
    for (int k = 0; k < NUM_ROMS; k++) begin
      io_out[4*k +: 4] = io_lat_r[k];
      if (sel_off_s == 4'(k)) begin
        rd_val_s = (IO_MASK[4*k +: 4] & io_s2_r[4*k +: 4]) | (~IO_MASK[4*k +: 4] & io_lat_r[k]);
      end
    end
  end

  // Bus drive per phase
  always_comb begin
    dbus_out = 4'h0;
    dbus_oe  = 1'b0;
    if (active_r) begin
      case (phase_r)
        PH_M1: if (fetch_hit_s) begin dbus_out = rdata_r[7:4]; dbus_oe = 1'b1; end
        PH_M2: if (fetch_hit_s) begin dbus_out = rdata_r[3:0]; dbus_oe = 1'b1; end
        PH_X2: if (rdr_s)       begin dbus_out = rd_val_s;     dbus_oe = 1'b1; end
        default: ;
      endcase
    end else begin
      dbus_oe = 1'b0;
    end
  end

  // Debug readback: out-of-range reads return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rdata     <= 8'h00;
      dbg_rdata_vld <= 1'b0;
    end else if (dbg_ren) begin
      dbg_rdata_vld <= 1'b1;
      dbg_rdata     <= id_in_range(dbg_addr[11:8]) ?
                       mem[AW'({chip_off(dbg_addr[11:8]), dbg_addr[7:0]})] : 8'h00;
    end else begin
      dbg_rdata_vld <= 1'b0;
    end
  end

endmodule
